// File: rtl/lsu_warp_ctrl_if.sv
// Bundles the execute-stage request, main_mem port and writeback response of the warp LSU.
// master = execute/memory/writeback side, slave = lsu_warp_ctrl.
interface lsu_warp_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_W      = 5
);
  localparam int THREADS = 32;

  logic                                req_valid;
  logic                                req_ready;
  logic                                req_we;
  logic                                req_size;
  logic                                req_signed;
  logic [THREADS-1:0]                  req_mask;
  logic [THREADS-1:0][31:0]            req_addr;
  logic [THREADS-1:0][DATA_WIDTH-1:0]  req_wdata;
  logic [TAG_W-1:0]                    req_tag;

  logic [THREADS-1:0]                  ram_en;
  logic                                ram_we;
  logic [THREADS-1:0][1:0]             ram_wstrb;
  logic [THREADS-1:0][31:0]            ram_addr;
  logic [THREADS-1:0][DATA_WIDTH-1:0]  ram_wdata;
  logic [THREADS-1:0][DATA_WIDTH-1:0]  ram_rdata;
  logic                                ram_done;

  logic                                resp_valid;
  logic                                resp_ready;
  logic                                resp_we;
  logic [TAG_W-1:0]                    resp_tag;
  logic [THREADS-1:0]                  resp_mask;
  logic [THREADS-1:0]                  resp_err;
  logic [THREADS-1:0][DATA_WIDTH-1:0]  resp_data;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_mask, req_addr, req_wdata, req_tag,
    output ram_rdata, ram_done, resp_ready,
    input  req_ready, ram_en, ram_we, ram_wstrb, ram_addr, ram_wdata,
    input  resp_valid, resp_we, resp_tag, resp_mask, resp_err, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_mask, req_addr, req_wdata, req_tag,
    input  ram_rdata, ram_done, resp_ready,
    output req_ready, ram_en, ram_we, ram_wstrb, ram_addr, ram_wdata,
    output resp_valid, resp_we, resp_tag, resp_mask, resp_err, resp_data
  );
endinterface

// File: rtl/lsu_warp_ctrl.sv
// Warp load/store controller: one 32-lane memory instruction at a time, IDLE -> ISSUE -> RESP.
// Request held on main_mem until ram_done; response held until resp_ready.
module lsu_warp_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_W      = 5
) (
  input  logic               clk,
  input  logic               reset,
  lsu_warp_ctrl_if.slave     bus
);
  localparam int THREADS = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state, state_nxt;

  // Captured instruction
  logic                                we_q;
  logic                                size_q;
  logic                                signed_q;
  logic [TAG_W-1:0]                    tag_q;
  logic [THREADS-1:0]                  emask_q;
  logic [THREADS-1:0]                  err_q;
  logic [THREADS-1:0]                  hi_q;
  logic [THREADS-1:0][31:0]            waddr_q;
  logic [THREADS-1:0][1:0]             wstrb_q;
  logic [THREADS-1:0][DATA_WIDTH-1:0]  wdata_q;
  logic [THREADS-1:0][DATA_WIDTH-1:0]  resp_data_q;

  // Per-lane request decode
  logic [THREADS-1:0]                  lane_misal;
  logic [THREADS-1:0]                  lane_err;
  logic [THREADS-1:0]                  lane_emask;
  logic [THREADS-1:0][31:0]            lane_waddr;
  logic [THREADS-1:0][1:0]             lane_wstrb;
  logic [THREADS-1:0][DATA_WIDTH-1:0]  lane_wdata;

  // Per-lane load extraction
  logic [THREADS-1:0][31:0]            lane_half;
  logic [THREADS-1:0][DATA_WIDTH-1:0]  lane_rdata;

  always_comb begin
    lane_misal = '0;
    lane_err   = '0;
    lane_emask = '0;
    lane_waddr = '0;
    lane_wstrb = '0;
    lane_wdata = '0;
    for (int i = 0; i < THREADS; i++) begin
      lane_misal[i] = bus.req_size ? (bus.req_addr[i][2:0] != 3'b000)
                                   : (bus.req_addr[i][1:0] != 2'b00);
      lane_err[i]   = bus.req_mask[i] & lane_misal[i];
      lane_emask[i] = bus.req_mask[i] & ~lane_misal[i];
      // Unserviced lanes present all-zero address/strobe/data to main_mem
      if (lane_emask[i]) begin
        lane_waddr[i] = {3'b000, bus.req_addr[i][31:3]};
        if (bus.req_size) begin
          lane_wstrb[i] = 2'b11;
          lane_wdata[i] = bus.req_wdata[i];
        end else begin
          lane_wstrb[i] = bus.req_addr[i][2] ? 2'b10 : 2'b01;
          lane_wdata[i] = {2{bus.req_wdata[i][31:0]}};
        end
      end
    end
  end

  always_comb begin
    lane_half  = '0;
    lane_rdata = '0;
    for (int i = 0; i < THREADS; i++) begin
      lane_half[i] = hi_q[i] ? bus.ram_rdata[i][63:32] : bus.ram_rdata[i][31:0];
      if (emask_q[i] && !we_q) begin
        if (size_q)
          lane_rdata[i] = bus.ram_rdata[i];
        else
          lane_rdata[i] = {{(DATA_WIDTH-32){signed_q & lane_half[i][31]}}, lane_half[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 1'b0;
      signed_q    <= 1'b0;
      tag_q       <= '0;
      emask_q     <= '0;
      err_q       <= '0;
      hi_q        <= '0;
      waddr_q     <= '0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.req_valid) begin
        we_q        <= bus.req_we;
        size_q      <= bus.req_size;
        signed_q    <= bus.req_signed;
        tag_q       <= bus.req_tag;
        emask_q     <= lane_emask;
        err_q       <= lane_err;
        for (int i = 0; i < THREADS; i++) hi_q[i] <= bus.req_addr[i][2];
        waddr_q     <= lane_waddr;
        wstrb_q     <= lane_wstrb;
        wdata_q     <= lane_wdata;
        resp_data_q <= '0;
      end
      if (state == ISSUE && bus.ram_done)
        resp_data_q <= lane_rdata;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.ram_en     = '0;
    bus.ram_we     = 1'b0;
    bus.ram_wstrb  = '0;
    bus.ram_addr   = '0;
    bus.ram_wdata  = '0;
    bus.resp_valid = 1'b0;
    bus.resp_we    = 1'b0;
    bus.resp_tag   = '0;
    bus.resp_mask  = '0;
    bus.resp_err   = '0;
    bus.resp_data  = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        // Empty or fully misaligned instructions never touch main_mem
        if (bus.req_valid)
          state_nxt = (lane_emask == '0) ? RESP : ISSUE;
      end
      ISSUE: begin
        bus.ram_en    = emask_q;
        bus.ram_we    = we_q;
        bus.ram_wstrb = wstrb_q;
        bus.ram_addr  = waddr_q;
        bus.ram_wdata = wdata_q;
        if (bus.ram_done)
          state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_we    = we_q;
        bus.resp_tag   = tag_q;
        bus.resp_mask  = emask_q;
        bus.resp_err   = err_q;
        bus.resp_data  = resp_data_q;
        if (bus.resp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/lsu_warp_ctrl.md
# lsu_warp_ctrl

Warp-level load/store controller between the SIMD32 execute stage and `main_mem`. Accepts one 32-thread memory instruction at a time, converts per-thread byte addresses into 64-bit word addresses plus half-word write strobes, and holds the request on the `main_mem` port until `ram_done`. It then returns aligned, sign- or zero-extended load data or a store acknowledgement to writeback through a valid/ready response.

## Interface
- `THREADS`, 32 (localparam), lanes per warp; fixed.
- `DATA_WIDTH`, 64, lane data width; must match `main_mem`.
- `TAG_W`, 5, width of the instruction tag echoed to writeback.

- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute stage offers an instruction.
- `req_ready`  out  1  controller can accept an instruction (high only in IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  1  0 = 32-bit access, 1 = 64-bit access.
- `req_signed`  in  1  sign-extend 32-bit loads when 1.
- `req_mask`  in  THREADS  active lanes.
- `req_addr`  in  THREADS×32  per-lane byte address.
- `req_wdata`  in  THREADS×DATA_WIDTH  per-lane store data; a 32-bit store uses bits [31:0].
- `req_tag`  in  TAG_W  instruction tag.
- `ram_en`  out  THREADS  to `main_mem`.
- `ram_we`  out  1  to `main_mem`.
- `ram_wstrb`  out  THREADS×2  [1] = upper 32 bits, [0] = lower 32 bits.
- `ram_addr`  out  THREADS×32  64-bit word address (byte address >> 3).
- `ram_wdata`  out  THREADS×DATA_WIDTH  store data placed in the lane's target half.
- `ram_rdata`  in  THREADS×DATA_WIDTH  from `main_mem`.
- `ram_done`  in  1  single-cycle pulse; the whole request is fulfilled.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  writeback accepts the response.
- `resp_we`, `resp_tag`  out  1, TAG_W  echoed from the request.
- `resp_mask`  out  THREADS  lanes actually serviced.
- `resp_err`  out  THREADS  lanes dropped as misaligned.
- `resp_data`  out  THREADS×DATA_WIDTH  load results; 0 for stores and unserviced lanes.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, register every request field and compute the per-lane values below, then move to ISSUE. If the effective mask is 0, go straight to RESP instead.
- Per-lane alignment: a 64-bit access needs addr[2:0]=0. A 32-bit access needs addr[1:0]=0.
- `err[i]` = `req_mask[i]` & misaligned. Effective mask = `req_mask` & ~`err`.
- Word address = {3'b0, addr[31:3]}.
- Strobe: 64-bit access gives 2'b11. 32-bit access gives addr[2] ? 2'b10 : 2'b01.
- Store data: 32-bit store places wdata[31:0] in both halves; the strobe selects the half actually written. 64-bit store passes wdata unchanged.
- ISSUE: drive `ram_en` = effective mask and `ram_we` = `req_we`. Hold the captured `ram_addr`/`ram_wstrb`/`ram_wdata` stable every cycle.
- ISSUE exit: in the cycle `ram_done`=1, capture `ram_rdata` and move to RESP.
- Load extraction per serviced lane:
  - 64-bit: the word as-is.
  - 32-bit: select the half by addr[2], then sign-extend (`req_signed`=1) or zero-extend to 64 bits.
- RESP: `resp_valid`=1 with all response fields held stable. On `resp_ready`, return to IDLE.
- `ram_en` is 0 in every state except ISSUE. It is therefore 0 in the cycle after `ram_done`, which prevents `main_mem` from re-launching.
- Outputs not in use drive 0.
- Reset (any state, including mid-ISSUE): next cycle is IDLE.
  - Reset values: `req_ready`=1; `resp_valid`=0; `ram_en`=0, `ram_we`=0.
  - All data, address, strobe, mask, err and tag outputs are 0.
  - An in-flight request is discarded.
- A `ram_done` seen outside ISSUE is ignored.

## Timing
- Request accepted at edge T (`req_valid`&`req_ready`). ISSUE is visible from cycle T+1, with `ram_en` high from T+1.
- `ram_done` seen high in cycle D: `resp_valid` is high from D+1 and `ram_en`=0 from D+1.
- Empty or all-misaligned request: `resp_valid` at T+1, with no `ram_en` activity.
- Back-to-back: a response accepted at edge R makes `req_ready`=1 in cycle R+1. Throughput is one instruction per (memory latency + 2) cycles minimum.
- `resp_valid` and response fields stay stable while `resp_ready`=0, for an unbounded stall.

## Test plan
- 64-bit load, all 32 lanes, lane i addr = 8·i, memory preloaded with word i = 0x1000+i -> `ram_addr[i]`=i and `ram_wstrb`=2'b11. `resp_data[i]`=0x1000+i, `resp_mask`=0xFFFFFFFF, `resp_err`=0.
- 32-bit store, lane 0 addr 0x4, data 0xDEADBEEF, mask=0x1 -> `ram_wstrb[0]`=2'b10 and `ram_wdata[0]`=0xDEADBEEF_DEADBEEF. A following 64-bit load of addr 0 returns upper half 0xDEADBEEF with the lower half unchanged.
- 32-bit signed load of 0x80000001 from addr 0x0 -> 0xFFFFFFFF80000001. With `req_signed`=0 -> 0x0000000080000001.
- Mask 0x3: lane 0 addr 0x4 size 64, lane 1 addr 0x8 size 64 -> `resp_err`=0x1, `ram_en`=0x2, `resp_mask`=0x2.
- Mask 0 -> `resp_valid` at T+1 and `ram_en` never asserted. With `resp_ready` held low for 5 cycles, the response is held stable and `req_ready` stays 0.
- Reset asserted two cycles into ISSUE -> next cycle `ram_en`=0, `resp_valid`=0, `req_ready`=1. A new load then completes normally.
